// File: rtl/uart_pkg.sv
// Shared types and sizes for the UART receive path.
package uart_pkg;
    localparam int DATA_W        = 8;
    localparam int RX_FIFO_DEPTH = 4;
    localparam int RX_FIFO_AW    = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;
endpackage

// File: rtl/uart_receiver_fifo.sv
// Small receive FIFO used when UART_RECEIVER_FIFO_EN is defined; a push while full
// is accepted only if a pop happens in the same cycle.
module uart_receiver_fifo
    import uart_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam logic [RX_FIFO_AW:0] FULL_CNT = (RX_FIFO_AW + 1)'(RX_FIFO_DEPTH);

    logic [DATA_W-1:0]     mem_q [RX_FIFO_DEPTH];
    logic [RX_FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [RX_FIFO_AW:0]   count_q, count_d;
    logic                  wr_en, rd_en;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign rd_en   = pop_i && !empty_o;
    // When full, the slot being written is the one being read this cycle.
    assign wr_en   = push_i && (!full_o || rd_en);

    always_comb begin
        count_d = count_q;
        if (wr_en && !rd_en) begin
            count_d = count_q + 1'b1;
        end else if (rd_en && !wr_en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RX_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with valid/ready delivery, framing-error and overrun pulses.
// Define UART_RECEIVER_FIFO_EN to replace the single holding register with a 4-entry FIFO.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 16,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);

    logic              sync1_q, sync2_q, rxs;
    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              byte_done;

    assign rxs       = sync2_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

    // Every timed state samples the line when cnt reaches 0, i.e. mid-bit.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        sr_d        = sr_q;
        frame_err_d = 1'b0;
        byte_done   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rxs) begin
                    cnt_d   = CNT_HALF;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rxs) begin
                    state_d = IDLE;
                end else begin
                    cnt_d     = CNT_FULL;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    sr_d  = {rxs, sr_q[DATA_W-1:1]};
                    cnt_d = CNT_FULL;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rxs) begin
                    byte_done = 1'b1;
                    state_d   = IDLE;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = BREAK;
                end
            end
            BREAK: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            sr_q        <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= rx;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            sr_q        <= sr_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RECEIVER_FIFO_EN
    logic fifo_full, fifo_empty, fifo_pop;

    assign fifo_pop  = !fifo_empty && rx_ready;
    assign rx_valid  = !fifo_empty;
    assign overrun_d = byte_done && fifo_full && !fifo_pop;

    uart_receiver_fifo u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (byte_done),
        .pop_i   (fifo_pop),
        .data_i  (sr_q),
        .data_o  (rx_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );
`else
    logic              hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;

    assign rx_valid = hold_valid_q;
    assign rx_data  = hold_data_q;

    // A new byte may replace the held one only if it is being popped this cycle.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        overrun_d    = 1'b0;
        if (byte_done) begin
            if (!hold_valid_q || rx_ready) begin
                hold_data_d  = sr_q;
                hold_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (hold_valid_q && rx_ready) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
        end
    end
`endif
endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver at BAUD_DIV=16.
module tb_uart_receiver;
    localparam int BD     = 16;
    localparam int PERIOD = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, busy;

    int total = 0;
    int bad   = 0;

    // Event log filled by the monitor; the stimulus only reads it.
    logic [7:0] acc_q[$];
    time        acc_t[$];
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         vld_cycles = 0;
    time        t_valid_rise = 0;
    time        t_fall = 0;
    logic       valid_prev = 1'b0;

    uart_receiver #(.BAUD_DIV(BD), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #(PERIOD / 2) clk = ~clk;

    always @(negedge clk) begin
        #1;
        if (rx_valid && !valid_prev) t_valid_rise = $time;
        valid_prev = rx_valid;
        if (rx_valid) vld_cycles++;
        if (rx_valid && rx_ready) begin
            acc_q.push_back(rx_data);
            acc_t.push_back($time);
        end
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] acc_at(input int i);
        if (i < acc_q.size()) return acc_q[i];
        return 8'hxx;
    endfunction

    function automatic longint acc_gap(input int i);
        if (i > 0 && i < acc_t.size()) return longint'(acc_t[i] - acc_t[i-1]);
        return -1;
    endfunction

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Caller is at a negedge; the line is left at the stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        t_fall = $time;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BD) @(negedge clk);
        end
        rx = stop;
        repeat (BD) @(negedge clk);
    endtask

    initial begin
        int     base, fe_base, ov_base, v_base;
        longint lat;

        repeat (4) @(negedge clk);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b1;
        idle(8);

        // single byte with consumer ready
        base = acc_q.size(); fe_base = fe_cnt; ov_base = ov_cnt; v_base = vld_cycles;
        send_frame(8'hA5, 1'b1);
        idle(20);
        lat = longint'((t_valid_rise - t_fall) / PERIOD);
        chk("t1_count", acc_q.size() - base, 1);
        chk("t1_data", acc_at(base), 8'hA5);
        chk("t1_latency", (lat >= 154 && lat <= 156), 1'b1);
        chk("t1_valid_cycles", vld_cycles - v_base, 1);
        chk("t1_frame_err", fe_cnt - fe_base, 0);
        chk("t1_overrun", ov_cnt - ov_base, 0);
        chk("t1_busy", busy, 1'b0);

        // two bytes while the consumer stalls
        rx_ready = 1'b0;
        base = acc_q.size(); ov_base = ov_cnt;
        send_frame(8'h3C, 1'b1);
        idle(4);
        send_frame(8'h81, 1'b1);
        idle(10);
`ifdef UART_RECEIVER_FIFO_EN
        chk("t2_overrun", ov_cnt - ov_base, 0);
`else
        chk("t2_overrun", ov_cnt - ov_base, 1);
`endif
        chk("t2_valid_held", rx_valid, 1'b1);
        chk("t2_data_held", rx_data, 8'h3C);
        chk("t2_none_taken", acc_q.size() - base, 0);
        rx_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("t2_valid_drop", rx_valid, 1'b0);
        chk("t2_first", acc_at(base), 8'h3C);
`ifdef UART_RECEIVER_FIFO_EN
        chk("t2_count", acc_q.size() - base, 2);
        chk("t2_second", acc_at(base + 1), 8'h81);
`else
        chk("t2_count", acc_q.size() - base, 1);
`endif

        // short low glitch on an idle line
        base = acc_q.size(); fe_base = fe_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        chk("t3_busy_high", busy, 1'b1);
        idle(12);
        chk("t3_busy_low", busy, 1'b0);
        chk("t3_no_byte", acc_q.size() - base, 0);
        chk("t3_no_frame_err", fe_cnt - fe_base, 0);

        // framing error followed by a break, then a good byte
        base = acc_q.size(); fe_base = fe_cnt;
        send_frame(8'h55, 1'b0);
        repeat (40) @(negedge clk);
        chk("t4_frame_err", fe_cnt - fe_base, 1);
        chk("t4_busy_in_break", busy, 1'b1);
        chk("t4_no_byte", acc_q.size() - base, 0);
        idle(20);
        chk("t4_busy_released", busy, 1'b0);
        send_frame(8'h12, 1'b1);
        idle(20);
        chk("t4_next_count", acc_q.size() - base, 1);
        chk("t4_next_data", acc_at(base), 8'h12);
        chk("t4_frame_err_once", fe_cnt - fe_base, 1);

        // reset in the middle of the data bits of 0xF0
        base = acc_q.size();
        rx = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 4; i++) repeat (BD) @(negedge clk);
        chk("t5_busy_before", busy, 1'b1);
        rst = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_rx_valid", rx_valid, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_frame_err", frame_err, 1'b0);
        chk("t5_overrun", overrun, 1'b0);
        chk("t5_rx_data", rx_data, 8'h00);
        rst = 1'b1;
        idle(200);
        chk("t5_no_byte", acc_q.size() - base, 0);
        send_frame(8'h0F, 1'b1);
        idle(20);
        chk("t5_after_count", acc_q.size() - base, 1);
        chk("t5_after_data", acc_at(base), 8'h0F);

        // back-to-back frames with no idle gap
        base = acc_q.size(); v_base = vld_cycles; ov_base = ov_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h5A, 1'b1);
        idle(20);
        chk("t6_count", acc_q.size() - base, 3);
        chk("t6_byte0", acc_at(base), 8'h00);
        chk("t6_byte1", acc_at(base + 1), 8'hFF);
        chk("t6_byte2", acc_at(base + 2), 8'h5A);
        chk("t6_gap01", 32'(acc_gap(base + 1)), 32'(10 * BD * PERIOD));
        chk("t6_gap12", 32'(acc_gap(base + 2)), 32'(10 * BD * PERIOD));
        chk("t6_valid_cycles", vld_cycles - v_base, 3);
        chk("t6_overrun", ov_cnt - ov_base, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- 8N1 UART receiver for the system's serial port: counterpart of the system's uart_tx transmitter.
- Samples an asynchronous serial line, recovers bytes LSB-first and delivers them on a valid/ready handshake to the CPU-side peripheral register logic.
- Reports framing errors and overruns as single-cycle pulses.

Parameters:
- BAUD_DIV, 16, clock cycles per serial bit; even, >= 4.
- CNT_W, 16, width of the bit-timing counter; must hold BAUD_DIV-1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- rx  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  8  received byte; stable while rx_valid=1.
- rx_valid  output  1  byte available.
- rx_ready  input  1  consumer accepts the byte when rx_valid & rx_ready at a clk edge.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: completed byte dropped because storage is full.
- busy  output  1  receiver not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - 2-flop synchronizer flops = 1.
  - State = IDLE; counter and bit index = 0.
  - rx_data = 0x00; rx_valid, frame_err, overrun, busy = 0.
  - Reset mid-frame discards the partial byte and any held byte.
- Input path: all logic uses rxs, the output of the 2-flop synchronizer (2-cycle delay).
- IDLE:
  - On rxs=0: cnt <= BAUD_DIV/2-1, go START.
- START:
  - cnt decrements each cycle.
  - At cnt=0, sample rxs. rxs=1 is a glitch: go IDLE, no output, no error.
  - Else cnt <= BAUD_DIV-1, bit index <= 0, go DATA.
- DATA:
  - At cnt=0: shift register <= {rxs, sr[7:1]}, cnt <= BAUD_DIV-1.
  - After the 8th sample, go STOP.
- STOP:
  - At cnt=0, sample rxs.
  - rxs=1: deliver the byte, go IDLE.
  - rxs=0: frame_err pulses 1 cycle, byte discarded, go BREAK.
- BREAK:
  - Wait until rxs=1, then go IDLE. This prevents a break condition from re-triggering START.
- busy = (state != IDLE).
- Delivery:
  - Byte loads into rx_data, and rx_valid is set on the edge after the stop sample, if storage is empty or is being popped the same cycle (rx_valid & rx_ready).
  - Otherwise the new byte is dropped, the old byte is kept, and overrun pulses 1 cycle.
- Handshake:
  - rx_valid stays high until accepted; no combinational path from rx_ready to rx_valid.
  - Back-to-back frames (next start bit immediately after the stop bit) must be received without loss.
- Latency: line falling edge to rx_valid = 2 + BAUD_DIV/2 + 9*BAUD_DIV + 1 cycles, ±1 for edge phase (155 ±1 at BAUD_DIV=16).
- Arithmetic: counter wraps never; it is only reloaded explicitly. Bit index is 3 bits and saturates at STOP entry.

Optional Feature:
- Macro UART_RECEIVER_FIFO_EN.
- Defined:
  - A 4-entry FIFO replaces the single holding register.
  - rx_valid = !empty; rx_data = head entry.
  - overrun only when all 4 entries are full and no pop occurs that cycle.
  - Simultaneous push and pop when full is legal and loses nothing.
- Undefined: single holding register as described under Behaviour.

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, START, DATA, STOP, BREAK};
  - DATA_W = 8;
  - RX_FIFO_DEPTH = 4;
  - RX_FIFO_AW = 2.
- Sub-module uart_receiver_fifo:
  - synchronous 4-entry FIFO, push/pop/full/empty;
  - instantiated only under UART_RECEIVER_FIFO_EN.
- Synchronizer and FSM stay in uart_receiver.

Test Plan:
1. BAUD_DIV=16, rx_ready=1, send 0xA5 8N1 -> rx_valid high exactly 1 cycle at ~155 cycles after start edge, rx_data=0xA5, frame_err=overrun=0.
2. rx_ready=0, send 0x3C then 0x81 -> rx_valid held with 0x3C, overrun pulses at second stop sample; raise rx_ready -> 0x3C accepted, rx_valid drops. With FIFO_EN: 0x3C then 0x81 delivered, no overrun.
3. rx low for 4 cycles then high -> no rx_valid, no frame_err, busy returns to 0 within 12 cycles.
4. Send 0x55 with stop bit 0, then hold low 40 cycles -> frame_err pulse once, no rx_valid, busy=1 until line high, then next byte 0x12 received correctly.
5. Assert rst mid-DATA of 0xF0, release with line idle -> all outputs 0, rx_valid never set for 0xF0; following 0x0F received correctly.
6. Back-to-back 0x00, 0xFF, 0x5A with no idle gap, rx_ready=1 -> three rx_valid pulses, 9*BAUD_DIV+... spacing of 10*BAUD_DIV cycles, data in order.
